serial_addsub: RTL and testbench

Parametrised bit/digit-serial adder-subtractor with valid/ready handshakes on both sides. It processes `DIGIT` bits per clock over a `WIDTH`-bit operand pair and returns the sum or difference with carry and signed-overflow flags. It sits between operand-producing control logic and a result consumer wherever area matters more than latency. It is the generalised successor of the team's fixed 8-bit serial adder.

---
 rtl/serial_addsub_pkg.sv | 16 +
 rtl/serial_add_digit.sv | 28 ++
 rtl/serial_addsub.sv | 123 ++++++++++++
 tb/tb_serial_addsub.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the digit-serial adder-subtractor: FSM state
// encoding and the parameter sanity check used at elaboration.
package serial_addsub_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t ADD  = 2'd1;
  localparam state_t DONE = 2'd2;

  // True when the width/digit combination can be processed in whole digits.
  function automatic bit width_ok(input int width, input int digit);
    return (width >= 2) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/serial_add_digit.sv
// Combinational DIGIT-bit ripple adder. Besides sum and carry-out it exposes
// the carry entering the top bit so the caller can derive signed overflow.
module serial_add_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_top
);

  // Ripple the carry from bit 0 upwards, noting the carry into the top bit.
  always_comb begin
    logic c;
    c     = cin;
    sum   = '0;
    c_top = cin;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_top = c;
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
    end
    cout = c;
  end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder-subtractor with valid/ready handshakes. Operands are
// latched on acceptance, then consumed DIGIT bits per cycle LSB first while
// the result fills in from the MSB end. Subtraction is done as A + ~B + ~borrow.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (!width_ok(WIDTH, DIGIT)) begin : g_bad_params
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t            state;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic              carry;
  logic [CW-1:0]     count;

  logic              accept;
  logic              step;
  logic              last;
  logic [DIGIT-1:0]  d_sum;
  logic              d_cout;
  logic              d_ctop;
  logic [WIDTH-1:0]  sum_next;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = (state == IDLE) && in_valid;
  assign step      = (state == ADD);
  assign last      = step && (count == LAST);
  assign sum_next  = WIDTH'({d_sum, sum} >> DIGIT);

  serial_add_digit #(.DIGIT(DIGIT)) u_digit (
    .a     (a_reg[DIGIT-1:0]),
    .b     (b_reg[DIGIT-1:0]),
    .cin   (carry),
    .sum   (d_sum),
    .cout  (d_cout),
    .c_top (d_ctop)
  );

  // Control FSM: accept in IDLE, run N digit steps, hold result until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else begin
      case (state)
        IDLE:    if (in_valid)  state <= ADD;
        ADD:     if (last)      state <= DONE;
        DONE:    if (out_ready) state <= IDLE;
        default:                state <= IDLE;
      endcase
    end
  end

  // Operand A: latch on acceptance, then shift out one digit per step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         a_reg <= '0;
    else if (accept) a_reg <= a;
    else if (step)   a_reg <= a_reg >> DIGIT;
  end

  // Operand B: inverted on acceptance for subtraction, then shifted like A.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         b_reg <= '0;
    else if (accept) b_reg <= sub ? ~b : b;
    else if (step)   b_reg <= b_reg >> DIGIT;
  end

  // Running carry between digits; a borrow-in becomes an inverted carry-in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         carry <= 1'b0;
    else if (accept) carry <= sub ? ~cin : cin;
    else if (step)   carry <= d_cout;
  end

  // Digit counter marking the final step of an operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 count <= '0;
    else if (accept)         count <= '0;
    else if (step && !last)  count <= count + 1'b1;
  end

  // Result accumulates from the MSB end so it lands aligned after N steps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         sum <= '0;
    else if (accept) sum <= '0;
    else if (step)   sum <= sum_next;
  end

  // Carry-out of the MSB, captured on the last digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cout <= 1'b0;
    else if (last) cout <= d_cout;
  end

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ovf <= 1'b0;
    else if (last) ovf <= d_ctop ^ d_cout;
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: a bit-serial 8-bit instance and a
// 4-bit-digit 16-bit instance share clock, reset and mode inputs.
module tb_serial_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic        sub;
  logic        cin;
  logic        out_ready;

  logic        in_valid8, in_ready8, out_valid8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;
  logic        in_valid16, in_ready16, out_valid16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;

  int checks   = 0;
  int failures = 0;
  int cycles;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .sub(sub), .cin(cin),
    .out_valid(out_valid8), .out_ready(out_ready),
    .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_addsub #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .sub(sub), .cin(cin),
    .out_valid(out_valid16), .out_ready(out_ready),
    .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present one operation to the chosen instance and wait for its result.
  task automatic start_op(input bit wide, input logic [15:0] av, input logic [15:0] bv,
                          input logic s, input logic c, input int n, input string tag);
    @(negedge clk);
    sub = s;
    cin = c;
    if (wide) begin a16 = av; b16 = bv; in_valid16 = 1'b1; end
    else begin a8 = av[7:0]; b8 = bv[7:0]; in_valid8 = 1'b1; end
    @(posedge clk);
    #1;
    in_valid8  = 1'b0;
    in_valid16 = 1'b0;
    check({tag, "_accept_in_ready"}, wide ? in_ready16 : in_ready8, 0);
    cycles = 0;
    while (!(wide ? out_valid16 : out_valid8) && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check({tag, "_latency"}, cycles, n);
  endtask

  // Hand the result to the consumer for one cycle.
  task automatic take_result(input bit wide, input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, wide ? out_valid16 : out_valid8, 0);
    check({tag, "_in_ready_back"},  wide ? in_ready16  : in_ready8,  1);
  endtask

  initial begin
    rst = 1'b1; sub = 1'b0; cin = 1'b0; out_ready = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0;
    in_valid16 = 1'b0; a16 = '0; b16 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_in_ready",  in_ready8,  1);
    check("rst_out_valid", out_valid8, 0);
    check("rst_sum",       sum8,       0);
    check("rst_cout",      cout8,      0);
    check("rst_ovf",       ovf8,       0);

    // 0x5A + 0x3C = 0x96, positive + positive goes negative.
    start_op(1'b0, 16'h005A, 16'h003C, 1'b0, 1'b0, 8, "add5a3c");
    check("add5a3c_sum",  sum8,  8'h96);
    check("add5a3c_cout", cout8, 0);
    check("add5a3c_ovf",  ovf8,  1);
    check("add5a3c_in_ready_done", in_ready8, 0);
    take_result(1'b0, "add5a3c");

    // 0x10 - 0x20 borrows: 0xF0, no carry (borrow), no signed overflow.
    start_op(1'b0, 16'h0010, 16'h0020, 1'b1, 1'b0, 8, "sub1020");
    check("sub1020_sum",  sum8,  8'hF0);
    check("sub1020_cout", cout8, 0);
    check("sub1020_ovf",  ovf8,  0);
    take_result(1'b0, "sub1020");

    // -128 - 1 wraps to +127.
    start_op(1'b0, 16'h0080, 16'h0001, 1'b1, 1'b0, 8, "sub8001");
    check("sub8001_sum",  sum8,  8'h7F);
    check("sub8001_cout", cout8, 1);
    check("sub8001_ovf",  ovf8,  1);
    take_result(1'b0, "sub8001");

    // 0xFF + 0x00 + 1 wraps to zero with carry, no signed overflow.
    start_op(1'b0, 16'h00FF, 16'h0000, 1'b0, 1'b1, 8, "addff_cin");
    check("addff_cin_sum",  sum8,  8'h00);
    check("addff_cin_cout", cout8, 1);
    check("addff_cin_ovf",  ovf8,  0);

    // Backpressure: result held while in_valid and a wiggle.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid8 = ~in_valid8;
      a8 = a8 + 8'h11;
      @(posedge clk);
      #1;
      check("bp_sum",       sum8,       8'h00);
      check("bp_cout",      cout8,      1);
      check("bp_out_valid", out_valid8, 1);
      check("bp_in_ready",  in_ready8,  0);
    end
    @(negedge clk);
    in_valid8 = 1'b0;
    take_result(1'b0, "bp");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_single_result", out_valid8, 0);
    end

    // 16-bit, 4-bit digits: 0x7FFF + 1 overflows into 0x8000 in 4 cycles.
    start_op(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 4, "w16_add");
    check("w16_add_sum",  sum16,  16'h8000);
    check("w16_add_cout", cout16, 0);
    check("w16_add_ovf",  ovf16,  1);
    take_result(1'b1, "w16_add");

    // Reset in the middle of ADD discards the operation.
    @(negedge clk);
    sub = 1'b0; cin = 1'b0; a16 = 16'h1234; b16 = 16'h4321; in_valid16 = 1'b1;
    @(posedge clk);
    #1;
    in_valid16 = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    check("midrst_sum",       sum16,       0);
    check("midrst_cout",      cout16,      0);
    check("midrst_ovf",       ovf16,       0);
    check("midrst_out_valid", out_valid16, 0);
    check("midrst_in_ready",  in_ready16,  1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("midrst_no_result", out_valid16, 0);
    end

    // Clean operation after the aborted one.
    start_op(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, 4, "w16_post");
    check("w16_post_sum",  sum16,  16'h5555);
    check("w16_post_cout", cout16, 0);
    check("w16_post_ovf",  ovf16,  0);
    take_result(1'b1, "w16_post");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
